// File: rtl/cmp_pkg.sv
// Shared types for the lockstep CPU bus-trace comparator.
// Trace entry layout, FSM encoding and fail-cause codes.
package cmp_pkg;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FAIL = 2'd3
  } cmp_state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISMATCH = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'd3;

endpackage

// File: rtl/trace_fifo.sv
// Single-clock FIFO for one trace stream.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign level   = cnt_q;
  assign head    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the counter alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cpu_trace_compare.sv
// Lockstep comparator for reference vs DUV CPU bus traces.
// Each side is queued so the two CPUs may run a few cycles apart.
module cpu_trace_compare
  import cmp_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     ref_valid,
  input  logic                     ref_rw,
  input  logic [ADDR_W-1:0]        ref_addr,
  input  logic [DATA_W-1:0]        ref_data,
  input  logic                     duv_valid,
  input  logic                     duv_rw,
  input  logic [ADDR_W-1:0]        duv_addr,
  input  logic [DATA_W-1:0]        duv_data,
  output logic [CNT_W-1:0]         match_count,
  output logic [CNT_W-1:0]         error_count,
  output logic                     fail,
  output logic [1:0]               fail_cause,
  output logic [ADDR_W+DATA_W:0]   fail_ref,
  output logic [ADDR_W+DATA_W:0]   fail_duv,
  output logic [1:0]               state
);

  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  cmp_state_e state_q, state_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fail_q, fail_d;
  logic [1:0]       cause_q, cause_d;
  logic [EW-1:0]    fref_q, fref_d;
  logic [EW-1:0]    fduv_q, fduv_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic [EW-1:0] ref_head, duv_head;
  logic          ref_full, ref_empty, duv_full, duv_empty;
  logic [LW-1:0] ref_lvl, duv_lvl;
  logic          active, ref_push, duv_push, do_cmp, same;
  logic          ovf, timeout, mismatch, new_fail, go_fail;
  logic          ref_ne_nx, duv_ne_nx, one_ne_nx;

  assign active   = enable && (state_q != ST_IDLE);
  assign ref_push = active && ref_valid;
  assign duv_push = active && duv_valid;
  assign do_cmp   = enable && !ref_empty && !duv_empty;
  assign same     = (ref_head == duv_head);
  assign mismatch = do_cmp && !same;
  assign ovf      = (ref_push && ref_full && !do_cmp) ||
                    (duv_push && duv_full && !do_cmp);

  trace_fifo #(.DEPTH(DEPTH), .W(EW)) u_ref_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!enable),
    .push  (ref_push),
    .pop   (do_cmp),
    .din   ({ref_rw, ref_addr, ref_data}),
    .head  (ref_head),
    .full  (ref_full),
    .empty (ref_empty),
    .level (ref_lvl)
  );

  trace_fifo #(.DEPTH(DEPTH), .W(EW)) u_duv_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!enable),
    .push  (duv_push),
    .pop   (do_cmp),
    .din   ({duv_rw, duv_addr, duv_data}),
    .head  (duv_head),
    .full  (duv_full),
    .empty (duv_empty),
    .level (duv_lvl)
  );

  // Occupancy after this edge, used to pick RUN vs WAIT.
  assign ref_ne_nx = (ref_lvl > LW'(1)) ||
                     (ref_lvl == LW'(1) && !do_cmp) || ref_push;
  assign duv_ne_nx = (duv_lvl > LW'(1)) ||
                     (duv_lvl == LW'(1) && !do_cmp) || duv_push;
  assign one_ne_nx = ref_ne_nx ^ duv_ne_nx;

  always_comb begin
    timer_d = timer_q;
    if (!enable || do_cmp || (ref_empty && duv_empty)) begin
      timer_d = '0;
    end else if (timer_q != TMAX) begin
      timer_d = timer_q + TW'(1);
    end
  end

  assign timeout  = (timer_d == TMAX) && (timer_q != TMAX);
  assign new_fail = !fail_q && (mismatch || ovf || timeout);
  assign go_fail  = !clear && (new_fail || ovf || timeout);

  always_comb begin
    match_d = match_q;
    err_d   = err_q;
    fail_d  = fail_q;
    cause_d = cause_q;
    fref_d  = fref_q;
    fduv_d  = fduv_q;
    if (do_cmp && same && match_q != '1) match_d = match_q + CNT_W'(1);
    if (mismatch && err_q != '1)         err_d   = err_q + CNT_W'(1);
    // Mismatch outranks overflow, which outranks timeout.
    if (new_fail) begin
      fail_d = 1'b1;
      if (mismatch) begin
        cause_d = CAUSE_MISMATCH;
        fref_d  = ref_head;
        fduv_d  = duv_head;
      end else if (ovf) begin
        cause_d = CAUSE_OVERFLOW;
      end else begin
        cause_d = CAUSE_TIMEOUT;
      end
    end
    if (clear) begin
      match_d = '0;
      err_d   = '0;
      fail_d  = 1'b0;
      cause_d = CAUSE_NONE;
      fref_d  = '0;
      fduv_d  = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (go_fail)        state_d = ST_FAIL;
          else if (one_ne_nx) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (go_fail)         state_d = ST_FAIL;
          else if (!one_ne_nx) state_d = ST_RUN;
        end
        ST_FAIL: begin
          if (clear) state_d = one_ne_nx ? ST_WAIT : ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      match_q <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
      fref_q  <= '0;
      fduv_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      cause_q <= cause_d;
      fref_q  <= fref_d;
      fduv_q  <= fduv_d;
      timer_q <= timer_d;
    end
  end

  assign match_count = match_q;
  assign error_count = err_q;
  assign fail        = fail_q;
  assign fail_cause  = cause_q;
  assign fail_ref    = fref_q;
  assign fail_duv    = fduv_q;
  assign state       = state_q;

endmodule

// File: tb/tb_cpu_trace_compare.sv
// Directed bench for cpu_trace_compare.
// Drives #1 after rising edges and samples at the same point.
module tb_cpu_trace_compare;
  import cmp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, enable, clear;
  logic        ref_valid, ref_rw, duv_valid, duv_rw;
  logic [15:0] ref_addr, duv_addr;
  logic [7:0]  ref_data, duv_data;
  logic [31:0] match_count, error_count;
  logic        fail;
  logic [1:0]  fail_cause, state;
  logic [24:0] fail_ref, fail_duv;

  int total = 0;
  int bad = 0;
  bit saw_wait;

  cpu_trace_compare dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .ref_valid(ref_valid), .ref_rw(ref_rw),
    .ref_addr(ref_addr), .ref_data(ref_data),
    .duv_valid(duv_valid), .duv_rw(duv_rw),
    .duv_addr(duv_addr), .duv_data(duv_data),
    .match_count(match_count), .error_count(error_count),
    .fail(fail), .fail_cause(fail_cause),
    .fail_ref(fail_ref), .fail_duv(fail_duv), .state(state)
  );

  always #5 clk = ~clk;

  function automatic trace_entry_t mk(int i);
    trace_entry_t e;
    if (i == 5) begin
      e = {1'b1, 16'h8000, 8'hA9};
    end else begin
      e.rw   = 1'(i);
      e.addr = 16'h7000 + 16'(i * 2);
      e.data = 8'(i * 3 + 1);
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ref(logic v, trace_entry_t e);
    ref_valid = v;
    {ref_rw, ref_addr, ref_data} = e;
  endtask

  task automatic drive_duv(logic v, trace_entry_t e);
    duv_valid = v;
    {duv_rw, duv_addr, duv_data} = e;
  endtask

  task automatic restart();
    drive_ref(1'b0, '0);
    drive_duv(1'b0, '0);
    enable = 1'b0;
    clear  = 1'b1;
    step();
    clear  = 1'b0;
    enable = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; clear = 1'b0;
    drive_ref(1'b0, '0);
    drive_duv(1'b0, '0);
    step(); step();
    total++;
    if (match_count !== 32'd0) begin
      bad++; $display("FAIL rst_match got=%0d exp=0", match_count);
    end
    total++;
    if (error_count !== 32'd0) begin
      bad++; $display("FAIL rst_error got=%0d exp=0", error_count);
    end
    total++;
    if ({fail, fail_cause} !== 3'd0) begin
      bad++; $display("FAIL rst_fail got=%0d/%0d exp=0/0", fail, fail_cause);
    end
    total++;
    if ({fail_ref, fail_duv} !== 50'd0) begin
      bad++; $display("FAIL rst_rec got=%h/%h exp=0", fail_ref, fail_duv);
    end
    total++;
    if (state !== 2'd0) begin
      bad++; $display("FAIL rst_state got=%0d exp=0", state);
    end
    #3 rst = 1'b0;
    enable = 1'b1;
    step();
    total++;
    if (state !== 2'd1) begin
      bad++; $display("FAIL idle_to_run got=%0d exp=1", state);
    end
  endtask

  task automatic test_identical();
    restart();
    for (int i = 0; i < 20; i++) begin
      drive_ref(1'b1, mk(i));
      drive_duv(1'b1, mk(i));
      step();
      if (i == 0) begin
        total++;
        if (match_count !== 32'd0) begin
          bad++; $display("FAIL lat_push got=%0d exp=0", match_count);
        end
      end
      if (i == 1) begin
        total++;
        if (match_count !== 32'd1) begin
          bad++; $display("FAIL lat_cmp got=%0d exp=1", match_count);
        end
      end
    end
    drive_ref(1'b0, '0);
    drive_duv(1'b0, '0);
    step(); step();
    total++;
    if (match_count !== 32'd20) begin
      bad++; $display("FAIL ident_match got=%0d exp=20", match_count);
    end
    total++;
    if (error_count !== 32'd0) begin
      bad++; $display("FAIL ident_error got=%0d exp=0", error_count);
    end
    total++;
    if (fail !== 1'b0) begin
      bad++; $display("FAIL ident_fail got=%0d exp=0", fail);
    end
    total++;
    if (state !== 2'd1) begin
      bad++; $display("FAIL ident_state got=%0d exp=1", state);
    end
  endtask

  task automatic test_mismatch();
    trace_entry_t d;
    restart();
    for (int i = 0; i < 20; i++) begin
      d = mk(i);
      if (i == 5) d.data = 8'hA8;
      drive_ref(1'b1, mk(i));
      drive_duv(1'b1, d);
      step();
    end
    drive_ref(1'b0, '0);
    drive_duv(1'b0, '0);
    step(); step();
    total++;
    if (error_count !== 32'd1) begin
      bad++; $display("FAIL mm_error got=%0d exp=1", error_count);
    end
    total++;
    if (match_count !== 32'd19) begin
      bad++; $display("FAIL mm_match got=%0d exp=19", match_count);
    end
    total++;
    if ({fail, fail_cause} !== {1'b1, 2'd1}) begin
      bad++; $display("FAIL mm_cause got=%0d/%0d exp=1/1", fail, fail_cause);
    end
    total++;
    if (fail_ref !== 25'h1_8000_A9) begin
      bad++; $display("FAIL mm_ref got=%h exp=18000a9", fail_ref);
    end
    total++;
    if (fail_duv !== 25'h1_8000_A8) begin
      bad++; $display("FAIL mm_duv got=%h exp=18000a8", fail_duv);
    end
    total++;
    if (state !== 2'd3) begin
      bad++; $display("FAIL mm_state got=%0d exp=3", state);
    end
  endtask

  task automatic test_skew();
    restart();
    saw_wait = 1'b0;
    for (int i = 0; i < 13; i++) begin
      drive_ref(i < 10, mk(i + 30));
      drive_duv(i >= 3, mk(i + 27));
      step();
      if (state == 2'd2) saw_wait = 1'b1;
    end
    drive_ref(1'b0, '0);
    drive_duv(1'b0, '0);
    step(); step(); step();
    total++;
    if (match_count !== 32'd10) begin
      bad++; $display("FAIL skew_match got=%0d exp=10", match_count);
    end
    total++;
    if ({fail, error_count} !== 33'd0) begin
      bad++; $display("FAIL skew_fail got=%0d/%0d exp=0/0", fail, error_count);
    end
    total++;
    if (saw_wait !== 1'b1) begin
      bad++; $display("FAIL skew_wait got=%0d exp=1", saw_wait);
    end
    total++;
    if (state !== 2'd1) begin
      bad++; $display("FAIL skew_state got=%0d exp=1", state);
    end
  endtask

  task automatic test_timeout();
    restart();
    drive_ref(1'b1, mk(40));
    step();
    drive_ref(1'b0, '0);
    repeat (63) step();
    total++;
    if ({fail, state} !== {1'b0, 2'd2}) begin
      bad++; $display("FAIL to_early got=%0d/%0d exp=0/2", fail, state);
    end
    step();
    total++;
    if ({fail, fail_cause} !== {1'b1, 2'd2}) begin
      bad++; $display("FAIL to_cause got=%0d/%0d exp=1/2", fail, fail_cause);
    end
    total++;
    if (state !== 2'd3) begin
      bad++; $display("FAIL to_state got=%0d exp=3", state);
    end
  endtask

  task automatic test_overflow();
    restart();
    for (int i = 0; i < 9; i++) begin
      drive_ref(1'b1, mk(50 + i));
      step();
      if (i == 7) begin
        total++;
        if ({fail, state} !== {1'b0, 2'd2}) begin
          bad++; $display("FAIL ovf_full got=%0d/%0d exp=0/2", fail, state);
        end
      end
    end
    drive_ref(1'b0, '0);
    total++;
    if ({fail, fail_cause} !== {1'b1, 2'd3}) begin
      bad++; $display("FAIL ovf_cause got=%0d/%0d exp=1/3", fail, fail_cause);
    end
    total++;
    if (state !== 2'd3) begin
      bad++; $display("FAIL ovf_state got=%0d exp=3", state);
    end
    for (int i = 0; i < 8; i++) begin
      drive_duv(1'b1, mk(50 + i));
      step();
    end
    drive_duv(1'b0, '0);
    step(); step();
    total++;
    if ({match_count, error_count} !== {32'd8, 32'd0}) begin
      bad++;
      $display("FAIL ovf_kept got=%0d/%0d exp=8/0", match_count, error_count);
    end
  endtask

  task automatic test_reset_mid();
    restart();
    for (int i = 0; i < 2; i++) begin
      drive_ref(1'b1, mk(60 + i));
      drive_duv(1'b1, mk(60 + i));
      step();
    end
    drive_duv(1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      drive_ref(1'b1, {1'b0, 16'h1234, 8'(i)});
      step();
    end
    drive_ref(1'b0, '0);
    total++;
    if (match_count !== 32'd2) begin
      bad++; $display("FAIL pre_rst_match got=%0d exp=2", match_count);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({match_count, state, fail} !== 35'd0) begin
      bad++;
      $display("FAIL async_rst got=%0d/%0d/%0d exp=0/0/0",
               match_count, state, fail);
    end
    #2 rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      drive_ref(1'b1, mk(70 + i));
      drive_duv(1'b1, mk(70 + i));
      step();
    end
    drive_ref(1'b0, '0);
    drive_duv(1'b0, '0);
    step(); step();
    total++;
    if ({match_count, error_count} !== {32'd3, 32'd0}) begin
      bad++;
      $display("FAIL realign got=%0d/%0d exp=3/0", match_count, error_count);
    end
    total++;
    if ({fail, state} !== {1'b0, 2'd1}) begin
      bad++; $display("FAIL realign_st got=%0d/%0d exp=0/1", fail, state);
    end
  endtask

  initial begin
    test_reset();
    test_identical();
    test_mismatch();
    test_skew();
    test_timeout();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
